// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the internal register bus between N_REQ masters.
// One transaction in flight; a bus-ack timeout keeps a dead target from hanging a master.
module reg_bus_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_rw,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic [DATA_W-1:0]       rdata,
  output logic                    bus_valid,
  output logic                    bus_rw,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [DATA_W-1:0]       bus_wdata,
  input  logic                    bus_ack,
  input  logic [DATA_W-1:0]       bus_rdata
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cur;
  logic [7:0]         timer;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 cand;
  logic               sel_rw;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Scan starts just after the last winner, so it has lowest priority next time.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % N_REQ;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(N_REQ - 1);
      cur       <= '0;
      timer     <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      bus_valid <= 1'b0;
      bus_rw    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          err  <= '0;
          if (win_found) begin
            state          <= BUSY;
            gnt            <= '0;
            gnt[win_idx]   <= 1'b1;
            rr_ptr         <= win_idx;
            cur            <= win_idx;
            timer          <= '0;
            bus_valid      <= 1'b1;
            bus_rw         <= sel_rw;
            bus_addr       <= sel_addr;
            bus_wdata      <= sel_wdata;
          end
        end
        // An ack on the last permitted cycle takes priority over the timeout.
        BUSY: begin
          if (bus_ack) begin
            state     <= DONE;
            done[cur] <= 1'b1;
            bus_valid <= 1'b0;
            if (!bus_rw) rdata <= bus_rdata;
          end else if (timer == TIMER_LAST) begin
            state     <= DONE;
            err[cur]  <= 1'b1;
            bus_valid <= 1'b0;
            rdata     <= '0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
          err   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: directed transactions push expected grants
// and responses; a monitor pops and compares whenever the DUT grants or completes.
module tb_reg_bus_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [3:0]   req_rw;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic [3:0]   err;
  logic [31:0]  rdata;
  logic         bus_valid;
  logic         bus_rw;
  logic [7:0]   bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_ack;
  logic [31:0]  bus_rdata;

  typedef struct {
    logic [3:0]  gnt;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          gap;
  } grant_t;

  typedef struct {
    logic [3:0]  done;
    logic [3:0]  err;
    logic [31:0] rdata;
    int          busy;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur_delay = 0;
  logic [31:0] cur_rdata = 32'h0;
  logic        mix_addr  = 1'b0;
  logic        stray_ack = 1'b0;

  reg_bus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .bus_valid (bus_valid),
    .bus_rw    (bus_rw),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_slice(input int idx, input logic rw, input logic [7:0] addr, input logic [31:0] wdata);
    req_rw[idx]               = rw;
    req_addr[idx*8 +: 8]      = addr;
    req_wdata[idx*32 +: 32]   = wdata;
  endtask

  task automatic push_grant(input int idx, input logic rw, input logic [7:0] addr,
                            input logic [31:0] wdata, input int gap);
    grant_t g;
    g.gnt = 4'(1 << idx); g.rw = rw; g.addr = addr; g.wdata = wdata; g.gap = gap;
    grant_q.push_back(g);
  endtask

  task automatic push_resp(input int idx, input logic is_err, input logic [31:0] exp_rdata, input int busy);
    resp_t r;
    r.done  = is_err ? 4'b0 : 4'(1 << idx);
    r.err   = is_err ? 4'(1 << idx) : 4'b0;
    r.rdata = exp_rdata;
    r.busy  = busy;
    resp_q.push_back(r);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((resp_q.size() != 0 || grant_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    if (resp_q.size() != 0 || grant_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d grants and %0d responses pending, expected 0",
               grant_q.size(), resp_q.size());
      grant_q.delete();
      resp_q.delete();
    end
  endtask

  // delay=0 means the target never acks, so the transaction must time out.
  task automatic applyStimulus(input int idx, input logic rw, input logic [7:0] addr,
                               input logic [31:0] wdata, input int delay,
                               input logic [31:0] tgt_rdata, input logic [31:0] exp_rdata);
    logic is_err;
    is_err    = (delay == 0);
    set_slice(idx, rw, addr, wdata);
    cur_delay = delay;
    cur_rdata = tgt_rdata;
    mix_addr  = 1'b0;
    push_grant(idx, rw, addr, wdata, -1);
    push_resp(idx, is_err, exp_rdata, is_err ? 15 : delay);
    req[idx] = 1'b1;
    wait_drain(100);
    req[idx] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b0;
    repeat (3) tick();
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_bus_valid", 32'(bus_valid), 32'h0);
    checkOutput("reset_bus_addr", 32'(bus_addr), 32'h0);
    checkOutput("reset_bus_wdata", bus_wdata, 32'h0);
    reset = 1'b1;
    tick();
  endtask

  // Target model: acks on the cur_delay-th BUSY cycle.
  initial begin
    int busy_cnt;
    busy_cnt  = 0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_valid) begin
        busy_cnt++;
        if (cur_delay != 0 && busy_cnt == cur_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = mix_addr ? (cur_rdata ^ {24'h0, bus_addr}) : cur_rdata;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = 32'h0;
        end
      end else begin
        busy_cnt  = 0;
        bus_ack   = stray_ack;
        bus_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // Monitor: compares each new grant and each done/err pulse against the queues.
  initial begin
    logic   prev_valid;
    int     busy_len;
    int     gap;
    grant_t g;
    resp_t  r;
    prev_valid = 1'b0;
    busy_len   = 0;
    gap        = 1000;
    forever begin
      @(negedge clk);
      if (bus_valid && !prev_valid) begin
        if (grant_q.size() == 0) begin
          checkOutput("unexpected_grant", 32'(gnt), 32'h0);
        end else begin
          g = grant_q.pop_front();
          checkOutput("grant_gnt", 32'(gnt), 32'(g.gnt));
          checkOutput("grant_bus_rw", 32'(bus_rw), 32'(g.rw));
          checkOutput("grant_bus_addr", 32'(bus_addr), 32'(g.addr));
          checkOutput("grant_bus_wdata", bus_wdata, g.wdata);
          if (g.gap >= 0) checkOutput("idle_gap", gap, g.gap);
        end
      end
      if (bus_valid) busy_len++;
      if (done != 4'b0 || err != 4'b0) begin
        if (resp_q.size() == 0) begin
          checkOutput("unexpected_done_err", {24'h0, done, err}, 32'h0);
        end else begin
          r = resp_q.pop_front();
          checkOutput("resp_done", 32'(done), 32'(r.done));
          checkOutput("resp_err", 32'(err), 32'(r.err));
          checkOutput("resp_rdata", rdata, r.rdata);
          checkOutput("resp_gnt_held", 32'(gnt), 32'(r.done | r.err));
          checkOutput("resp_busy_cycles", busy_len, r.busy);
        end
      end
      if (!bus_valid) begin
        if (done != 4'b0 || err != 4'b0) gap = 0;
        else gap++;
        busy_len = 0;
      end
      prev_valid = bus_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int n;
    reset     = 1'b0;
    req       = 4'b0;
    req_rw    = 4'b0;
    req_addr  = 32'h0;
    req_wdata = 128'h0;
    do_reset();

    // T1: single write by requester 1, ack on the third BUSY cycle.
    applyStimulus(1, 1'b1, 8'h10, 32'hA5A5A5A5, 3, 32'h0, 32'h0);
    tick();

    // T2: all four requesting continuously, fresh pointer after reset.
    do_reset();
    for (int i = 0; i < 4; i++) set_slice(i, 1'b0, 8'(8'h20 + i), 32'h1000 + i);
    cur_delay = 1;
    cur_rdata = 32'hCAFE0000;
    mix_addr  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_grant(k % 4, 1'b0, 8'(8'h20 + (k % 4)), 32'h1000 + (k % 4), (k == 0) ? -1 : 1);
      push_resp(k % 4, 1'b0, 32'hCAFE0000 ^ (32'h20 + (k % 4)), 1);
    end
    req = 4'b1111;
    wait_drain(100);
    req = 4'b0;
    tick();

    // T3: read that is never acked times out after 15 BUSY cycles.
    applyStimulus(2, 1'b0, 8'h30, 32'h0, 0, 32'h0, 32'h0);
    tick();

    // T4: ack on the last permitted cycle, then writes must not disturb rdata.
    applyStimulus(1, 1'b0, 8'h44, 32'h0, 15, 32'h12345678, 32'h12345678);
    tick();
    applyStimulus(3, 1'b1, 8'h50, 32'hDEADBEEF, 2, 32'hFFFFFFFF, 32'h12345678);
    tick();
    applyStimulus(0, 1'b1, 8'h51, 32'h01234567, 1, 32'hFFFFFFFF, 32'h12345678);
    tick();
    checkOutput("rdata_hold_idle", rdata, 32'h12345678);

    // T5: reset mid-transaction abandons it silently.
    set_slice(2, 1'b0, 8'h70, 32'h0);
    cur_delay = 0;
    mix_addr  = 1'b0;
    push_grant(2, 1'b0, 8'h70, 32'h0, -1);
    req[2] = 1'b1;
    n = 0;
    while (!bus_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t5_busy_reached", 32'(bus_valid), 32'h1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("t5_gnt_cleared", 32'(gnt), 32'h0);
    checkOutput("t5_bus_valid_cleared", 32'(bus_valid), 32'h0);
    checkOutput("t5_done_cleared", 32'(done), 32'h0);
    checkOutput("t5_err_cleared", 32'(err), 32'h0);
    checkOutput("t5_rdata_cleared", rdata, 32'h0);
    req = 4'b0;
    tick();
    for (int i = 0; i < 4; i++) set_slice(i, 1'b0, 8'(8'h80 + i), 32'h0);
    cur_delay = 1;
    cur_rdata = 32'h55AA55AA;
    push_grant(0, 1'b0, 8'h80, 32'h0, -1);
    push_resp(0, 1'b0, 32'h55AA55AA, 1);
    reset = 1'b1;
    req   = 4'b1111;
    wait_drain(100);
    req = 4'b0;
    tick();

    // T6: stray ack while idle must produce nothing.
    stray_ack = 1'b1;
    repeat (3) tick();
    checkOutput("t6_idle_bus_valid", 32'(bus_valid), 32'h0);
    checkOutput("t6_idle_done", 32'(done), 32'h0);
    stray_ack = 1'b0;
    repeat (2) tick();
    applyStimulus(3, 1'b1, 8'h60, 32'h0F0F0F0F, 2, 32'hFFFFFFFF, 32'h55AA55AA);
    repeat (3) tick();

    checkOutput("queues_empty", 32'(grant_q.size() + resp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
